multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle MIPS main control FSM, directly upstream of the ALU control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives datapath mux/enable signals and the 3-bit `alu_op` code that the ALU control decoder combines with the funct field. Memory accesses wait on a ready handshake. A retired-instruction counter and a sticky illegal-opcode flag are provided for debug.

## Interface
- `COUNT_WIDTH`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `zero` in 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC load enable.
- `ior_d` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_read`, `mem_write`, `ir_write` out 1 each.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = MDR, 0 = ALUOut.
- `reg_write` out 1.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = const 4, 10 = ext imm, 11 = sign-ext imm<<2.
- `zero_ext` out 1: immediate extender uses zero-extension.
- `alu_op` out 3: 111 R-type, 100 add, 101 or, 001 compare (branch).
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: sticky; set on entry to TRAP.
- `instr_count` out COUNT_WIDTH: number of retired instructions.

## Operation
- State register is 4 bits, async-cleared to FETCH.
- Outputs are a Moore decode of the state. The exceptions are `pc_write`, which is gated by `mem_ready`/`zero` as listed below, and the ADDI/ORI distinction in I_EXEC. Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `alu_src_b`=01, `alu_op`=100, `ir_write`=`pc_write`=`mem_ready`. Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `alu_src_b`=11, `alu_op`=100 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXECUTE
  - 001000 (ADDI), 001101 (ORI) → I_EXEC
  - 100011 (LW), 101011 (SW) → MEM_ADDR
  - 000100 (BEQ), 000101 (BNE) → BRANCH
  - 000010 (J) → JUMP
  - anything else → TRAP
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=111 → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1 → FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10. For ADDI, `alu_op`=100. For ORI, `alu_op`=101 and `zero_ext`=1. → I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=100 → MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `mem_read`=1, `ior_d`=1. Hold while `mem_ready`=0, then → MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
- MEM_WRITE: `mem_write`=1, `ior_d`=1. Hold while `mem_ready`=0, then → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_source`=01. `pc_write` = (BEQ & `zero`) | (BNE & ~`zero`). → FETCH.
- JUMP: `pc_source`=10, `pc_write`=1 → FETCH.
- TRAP: all control outputs are 0 and `illegal_op`=1. The FSM stays in TRAP until reset.
- `instr_count` increments by 1 on every transition into FETCH from R_WB, I_WB, MEM_WB, BRANCH or JUMP, and from MEM_WRITE when `mem_ready`=1. It wraps modulo 2^COUNT_WIDTH.
- `opcode` is sampled combinationally in DECODE, I_EXEC, MEM_ADDR and BRANCH. The IR holds it stable from DECODE until the next FETCH completes.

## Timing
- Cycle counts with `mem_ready` held at 1:
  - R-type, ADDI, ORI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, BNE, J: 3 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds 1 cycle.
- Stalled FETCH cycles assert neither `ir_write` nor `pc_write`, so the PC advances exactly once per fetch.
- Reset asserted at any time, including mid-instruction or mid-stall, forces FETCH, `instr_count`=0 and `illegal_op`=0 immediately.
- Values while `reset`=0:
  - `mem_read`=1, `alu_src_b`=01, `alu_op`=100.
  - `ir_write` and `pc_write` follow `mem_ready`.
  - All other outputs are 0.
- The first fetch begins on the first rising edge after `reset` is released.

## Test plan
- R-type: ADD (opcode 000000), `mem_ready`=1 → state sequence FETCH, DECODE, EXECUTE (`alu_op`=111), R_WB (`reg_write`=1, `reg_dst`=1). `instr_count` goes 0→1 on the 4th edge.
- LW with memory stall: `mem_ready`=0 for 2 cycles in MEM_READ → MEM_READ held 3 cycles, then MEM_WB with `mem_to_reg`=1. Total 7 cycles; `pc_write` is pulsed exactly once.
- Branches:
  - BEQ with `zero`=1 in BRANCH → `pc_write`=1, `pc_source`=01.
  - BEQ with `zero`=0 → `pc_write`=0.
  - BNE with `zero`=0 → `pc_write`=1.
- ORI: I_EXEC shows `alu_op`=101 and `zero_ext`=1. ADDI: I_EXEC shows `alu_op`=100 and `zero_ext`=0. Both then pass through I_WB with `reg_write`=1, `reg_dst`=0.
- Illegal opcode 111111 → TRAP one cycle after DECODE. `illegal_op`=1 and all control outputs 0 for 10+ cycles. Asserting `reset` clears the flag and returns the FSM to FETCH.
- Counter wrap with COUNT_WIDTH=4: 16 J instructions → `instr_count` returns to 0. Asserting reset mid-EXECUTE clears the count and restarts at FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback
// sequencing, datapath control decode, retired-instruction count, illegal flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   ior_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic                   zero_ext,
  output logic [2:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic                   illegal_op,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  localparam logic [2:0] c_ALU_ADD  = 3'b100;
  localparam logic [2:0] c_ALU_OR   = 3'b101;
  localparam logic [2:0] c_ALU_CMP  = 3'b001;
  localparam logic [2:0] c_ALU_RTYP = 3'b111;

  localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXECUTE   = 4'd2,
    S_R_WB      = 4'd3,
    S_I_EXEC    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     w_retire;
  logic                     r_illegal;
  logic [COUNT_WIDTH-1:0]   r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == S_TRAP)
        r_illegal <= 1'b1;
      if (w_retire)
        r_count <= r_count + c_COUNT_ONE;
    end
  end

  // An instruction retires on the cycle its final state hands back to FETCH.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEM_WRITE:                                w_retire = mem_ready;
      default:                                    w_retire = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    pc_write     = 1'b0;
    ior_d        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    zero_ext     = 1'b0;
    alu_op       = 3'b000;
    pc_source    = 2'b00;

    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = c_ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)
          w_state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = c_ALU_ADD;
        case (opcode)
          c_OP_RTYPE:          w_state_next = S_EXECUTE;
          c_OP_ADDI, c_OP_ORI: w_state_next = S_I_EXEC;
          c_OP_LW, c_OP_SW:    w_state_next = S_MEM_ADDR;
          c_OP_BEQ, c_OP_BNE:  w_state_next = S_BRANCH;
          c_OP_J:              w_state_next = S_JUMP;
          default:             w_state_next = S_TRAP;
        endcase
      end
      S_EXECUTE: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b00;
        alu_op       = c_ALU_RTYP;
        w_state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_write    = 1'b1;
        reg_dst      = 1'b1;
        w_state_next = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        if (opcode == c_OP_ORI) begin
          alu_op   = c_ALU_OR;
          zero_ext = 1'b1;
        end else begin
          alu_op   = c_ALU_ADD;
        end
        w_state_next = S_I_WB;
      end
      S_I_WB: begin
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_op       = c_ALU_ADD;
        w_state_next = (opcode == c_OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        if (mem_ready)
          w_state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        if (mem_ready)
          w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b00;
        alu_op       = c_ALU_CMP;
        pc_source    = 2'b01;
        pc_write     = ((opcode == c_OP_BEQ) & zero) | ((opcode == c_OP_BNE) & ~zero);
        w_state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_source    = 2'b10;
        pc_write     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_TRAP: begin
        w_state_next = S_TRAP;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  assign illegal_op  = r_illegal;
  assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control
// Directed vectors with hand-computed control words for multicycle_control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ior_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, zero_ext, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;
  int pcw_pulses;

  multicycle_control #(.COUNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .zero_ext(zero_ext), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Field order: pcw iord mr mw irw rd m2r rw asa | asb | zext | alu_op | pc_src
  logic [31:0] w_ctl;
  assign w_ctl = {15'd0, pc_write, ior_d, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, zero_ext, alu_op, pc_source};

  localparam logic [31:0] E_FETCH  = {15'd0, 9'b101010000, 2'b01, 1'b0, 3'b100, 2'b00};
  localparam logic [31:0] E_FSTALL = {15'd0, 9'b001000000, 2'b01, 1'b0, 3'b100, 2'b00};
  localparam logic [31:0] E_DECODE = {15'd0, 9'b000000000, 2'b11, 1'b0, 3'b100, 2'b00};
  localparam logic [31:0] E_EXEC   = {15'd0, 9'b000000001, 2'b00, 1'b0, 3'b111, 2'b00};
  localparam logic [31:0] E_RWB    = {15'd0, 9'b000001010, 2'b00, 1'b0, 3'b000, 2'b00};
  localparam logic [31:0] E_ADDI   = {15'd0, 9'b000000001, 2'b10, 1'b0, 3'b100, 2'b00};
  localparam logic [31:0] E_ORI    = {15'd0, 9'b000000001, 2'b10, 1'b1, 3'b101, 2'b00};
  localparam logic [31:0] E_IWB    = {15'd0, 9'b000000010, 2'b00, 1'b0, 3'b000, 2'b00};
  localparam logic [31:0] E_MADDR  = {15'd0, 9'b000000001, 2'b10, 1'b0, 3'b100, 2'b00};
  localparam logic [31:0] E_MREAD  = {15'd0, 9'b011000000, 2'b00, 1'b0, 3'b000, 2'b00};
  localparam logic [31:0] E_MWB    = {15'd0, 9'b000000110, 2'b00, 1'b0, 3'b000, 2'b00};
  localparam logic [31:0] E_MWRITE = {15'd0, 9'b010100000, 2'b00, 1'b0, 3'b000, 2'b00};
  localparam logic [31:0] E_BR_T   = {15'd0, 9'b100000001, 2'b00, 1'b0, 3'b001, 2'b01};
  localparam logic [31:0] E_BR_N   = {15'd0, 9'b000000001, 2'b00, 1'b0, 3'b001, 2'b01};
  localparam logic [31:0] E_JUMP   = {15'd0, 9'b100000000, 2'b00, 1'b0, 3'b000, 2'b10};
  localparam logic [31:0] E_ZERO   = 32'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Checks the current cycle's control word, then advances to just after the next edge.
  task automatic cyc(input logic [31:0] exp, input string tag);
    #2;
    chk(tag, w_ctl, exp);
    if (pc_write) pcw_pulses++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_count(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, instr_count}, {28'd0, exp});
  endtask

  initial begin
    reset = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    #3;
    chk("rst_ctl_rdy", w_ctl, E_FETCH);
    chk_count("rst_count", 4'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    mem_ready = 1'b0;
    #1;
    chk("rst_ctl_stall", w_ctl, E_FSTALL);
    @(posedge clk); #1;
    chk_count("rst_count_hold", 4'd0);
    reset = 1'b1; mem_ready = 1'b1;

    // R-type
    opcode = 6'b000000;
    cyc(E_FETCH, "r_fetch"); cyc(E_DECODE, "r_decode"); cyc(E_EXEC, "r_exec");
    chk_count("r_count_pre", 4'd0);
    cyc(E_RWB, "r_wb");
    chk_count("r_count", 4'd1);

    // LW with two stall cycles in MEM_READ
    pcw_pulses = 0;
    opcode = 6'b100011;
    cyc(E_FETCH, "lw_fetch"); cyc(E_DECODE, "lw_decode"); cyc(E_MADDR, "lw_maddr");
    mem_ready = 1'b0;
    cyc(E_MREAD, "lw_mread_s0"); cyc(E_MREAD, "lw_mread_s1");
    mem_ready = 1'b1;
    cyc(E_MREAD, "lw_mread"); cyc(E_MWB, "lw_mwb");
    chk("lw_pcw_pulses", 32'(pcw_pulses), 32'd1);
    chk_count("lw_count", 4'd2);

    // Branches
    opcode = 6'b000100; zero = 1'b1;
    cyc(E_FETCH, "beq_t_fetch"); cyc(E_DECODE, "beq_t_decode"); cyc(E_BR_T, "beq_taken");
    zero = 1'b0;
    cyc(E_FETCH, "beq_n_fetch"); cyc(E_DECODE, "beq_n_decode"); cyc(E_BR_N, "beq_not");
    opcode = 6'b000101;
    cyc(E_FETCH, "bne_t_fetch"); cyc(E_DECODE, "bne_t_decode"); cyc(E_BR_T, "bne_taken");
    zero = 1'b1;
    cyc(E_FETCH, "bne_n_fetch"); cyc(E_DECODE, "bne_n_decode"); cyc(E_BR_N, "bne_not");
    chk_count("br_count", 4'd6);

    // ORI then ADDI
    opcode = 6'b001101;
    cyc(E_FETCH, "ori_fetch"); cyc(E_DECODE, "ori_decode"); cyc(E_ORI, "ori_exec"); cyc(E_IWB, "ori_wb");
    opcode = 6'b001000;
    cyc(E_FETCH, "addi_fetch"); cyc(E_DECODE, "addi_decode"); cyc(E_ADDI, "addi_exec"); cyc(E_IWB, "addi_wb");
    chk_count("imm_count", 4'd8);

    // SW with one stalled fetch and one stalled write
    opcode = 6'b101011; mem_ready = 1'b0;
    cyc(E_FSTALL, "sw_fetch_stall");
    mem_ready = 1'b1;
    cyc(E_FETCH, "sw_fetch"); cyc(E_DECODE, "sw_decode"); cyc(E_MADDR, "sw_maddr");
    mem_ready = 1'b0;
    cyc(E_MWRITE, "sw_mwrite_stall");
    chk_count("sw_count_stall", 4'd8);
    mem_ready = 1'b1;
    cyc(E_MWRITE, "sw_mwrite");
    chk_count("sw_count", 4'd9);

    // Reset asserted mid-EXECUTE
    opcode = 6'b000000;
    cyc(E_FETCH, "rx_fetch"); cyc(E_DECODE, "rx_decode");
    reset = 1'b0;
    #1;
    chk("rx_ctl", w_ctl, E_FETCH);
    chk_count("rx_count", 4'd0);
    reset = 1'b1;

    // 16 jumps wrap the 4-bit counter back to zero
    opcode = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      cyc(E_FETCH, "j_fetch"); cyc(E_DECODE, "j_decode"); cyc(E_JUMP, "j_jump");
      chk_count("j_count", 4'((i + 1) % 16));
    end

    // Illegal opcode traps until reset
    opcode = 6'b111111;
    cyc(E_FETCH, "trap_fetch");
    chk("trap_pre_flag", {31'd0, illegal_op}, 32'd0);
    cyc(E_DECODE, "trap_decode");
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'(i & 1);
      zero      = 1'((i >> 1) & 1);
      chk("trap_flag", {31'd0, illegal_op}, 32'd1);
      cyc(E_ZERO, "trap_ctl");
    end
    mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("trap_rst_flag", {31'd0, illegal_op}, 32'd0);
    chk("trap_rst_ctl", w_ctl, E_FETCH);
    reset = 1'b1; opcode = 6'b000000;
    cyc(E_FETCH, "post_fetch"); cyc(E_DECODE, "post_decode"); cyc(E_EXEC, "post_exec");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
